unidad_de_busqueda: RTL

Instruction fetch and sequencing stage that sits directly upstream of the control unit. It holds the program counter and fetches 9-bit instructions from instruction memory over a request/acknowledge handshake. It presents the opcode and operand fields to the control unit and generates the one-cycle o_Timming strobe that clocks the control unit. It consumes the control unit's jump signal and selects the next program counter value.

---
 rtl/unidad_de_busqueda.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/unidad_de_busqueda.sv
// Instruction fetch/sequencing ahead of the control unit; UNIDAD_BUSQUEDA_PASO_A_PASO_EN adds single-step gating on i_Paso.
// Latency: 3+CICLOS_EJEC cycles per instruction with a zero-wait memory (one extra idle cycle after reset).
// Backpressure: fetch holds address/request until i_Ack_mem; i_Stall freezes the EJEC count.
module unidad_de_busqueda #(
    parameter int ANCHO_PC    = 8,
    parameter int CICLOS_EJEC = 2
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    output logic [ANCHO_PC-1:0] o_Dir_mem,
    output logic                o_Req_mem,
    input  logic                i_Ack_mem,
    input  logic [8:0]          i_Inst_mem,
    input  logic                i_Senal_de_salto,
    input  logic [ANCHO_PC-1:0] i_Dir_salto,
    input  logic                i_Stall,
`ifdef UNIDAD_BUSQUEDA_PASO_A_PASO_EN
    input  logic                i_Paso,
`endif
    output logic                o_Timming,
    output logic [2:0]          o_Operation_code,
    output logic [5:0]          o_Operandos,
    output logic [ANCHO_PC-1:0] o_PC_sig,
    output logic                o_Detenido
);

    localparam int CICLOS = (CICLOS_EJEC < 1) ? 1 : CICLOS_EJEC;
    localparam int CW     = (CICLOS > 1) ? $clog2(CICLOS) : 1;

    localparam logic [CW-1:0]       ULTIMO  = CW'(CICLOS - 1);
    localparam logic [CW-1:0]       CNT_UNO = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [ANCHO_PC-1:0] PC_UNO  = {{(ANCHO_PC-1){1'b0}}, 1'b1};
    localparam logic [8:0]          IR_NOP  = 9'b111_000_000;
    localparam logic [8:0]          IR_FIN  = 9'b111_111_111;
    localparam logic [2:0]          OP_SALTO = 3'b110;

    typedef enum logic [2:0] {
        BUSQ  = 3'd0,
        DECOD = 3'd1,
        EJEC  = 3'd2,
        SIG   = 3'd3,
        HALT  = 3'd4
`ifdef UNIDAD_BUSQUEDA_PASO_A_PASO_EN
        ,
        PAUSA = 3'd5
`endif
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [ANCHO_PC-1:0] pc_q, pc_d;
    logic [ANCHO_PC-1:0] pc_sig_q, pc_sig_d;
    logic [8:0]          ir_q, ir_d;
    logic                req_q, req_d;
    logic                timming_q, timming_d;
    logic                detenido_q, detenido_d;
    logic                salto_q, salto_d;
    logic [CW-1:0]       cnt_q, cnt_d;

`ifdef UNIDAD_BUSQUEDA_PASO_A_PASO_EN
    logic paso_prev_q, paso_prev_d;
    logic paso_flanco;
    assign paso_flanco = i_Paso & ~paso_prev_q;
`endif

    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        req_d      = req_q;
        timming_d  = 1'b0;
        detenido_d = detenido_q;
        salto_d    = salto_q;
        cnt_d      = cnt_q;
`ifdef UNIDAD_BUSQUEDA_PASO_A_PASO_EN
        paso_prev_d = i_Paso;
`endif
        case (estado_q)
            BUSQ: begin
                // Only an ack seen while our request is already visible counts.
                req_d = 1'b1;
                if (req_q && i_Ack_mem) begin
                    ir_d     = i_Inst_mem;
                    req_d    = 1'b0;
                    estado_d = DECOD;
                end
            end
            DECOD: begin
                cnt_d = '0;
                if (ir_q == IR_FIN) begin
                    detenido_d = 1'b1;
                    estado_d   = HALT;
                end else begin
                    timming_d = 1'b1;
                    estado_d  = EJEC;
                end
            end
            EJEC: begin
                if (!i_Stall) begin
                    if (cnt_q == ULTIMO) begin
                        salto_d  = i_Senal_de_salto && (ir_q[8:6] == OP_SALTO);
                        cnt_d    = '0;
                        estado_d = SIG;
                    end else begin
                        cnt_d = cnt_q + CNT_UNO;
                    end
                end
            end
            SIG: begin
                pc_d    = salto_q ? i_Dir_salto : pc_q + PC_UNO;
                salto_d = 1'b0;
`ifdef UNIDAD_BUSQUEDA_PASO_A_PASO_EN
                estado_d = PAUSA;
`else
                // Raise the request together with the new PC so BUSQ costs one cycle.
                req_d    = 1'b1;
                estado_d = BUSQ;
`endif
            end
`ifdef UNIDAD_BUSQUEDA_PASO_A_PASO_EN
            PAUSA: begin
                if (paso_flanco) begin
                    req_d    = 1'b1;
                    estado_d = BUSQ;
                end
            end
`endif
            HALT: begin
                req_d      = 1'b0;
                detenido_d = 1'b1;
            end
            default: begin
                req_d    = 1'b0;
                estado_d = BUSQ;
            end
        endcase
        pc_sig_d = pc_d + PC_UNO;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            estado_q   <= BUSQ;
            pc_q       <= '0;
            pc_sig_q   <= PC_UNO;
            ir_q       <= IR_NOP;
            req_q      <= 1'b0;
            timming_q  <= 1'b0;
            detenido_q <= 1'b0;
            salto_q    <= 1'b0;
            cnt_q      <= '0;
`ifdef UNIDAD_BUSQUEDA_PASO_A_PASO_EN
            paso_prev_q <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            pc_sig_q   <= pc_sig_d;
            ir_q       <= ir_d;
            req_q      <= req_d;
            timming_q  <= timming_d;
            detenido_q <= detenido_d;
            salto_q    <= salto_d;
            cnt_q      <= cnt_d;
`ifdef UNIDAD_BUSQUEDA_PASO_A_PASO_EN
            paso_prev_q <= paso_prev_d;
`endif
        end
    end

    assign o_Dir_mem        = pc_q;
    assign o_Req_mem        = req_q;
    assign o_Timming        = timming_q;
    assign o_Operation_code = ir_q[8:6];
    assign o_Operandos      = ir_q[5:0];
    assign o_PC_sig         = pc_sig_q;
    assign o_Detenido       = detenido_q;

endmodule
